// File: rtl/score_display.sv
`default_nettype none
// ============================================================================
// Module   : score_display
// Brief    : Multiplexed 4-digit seven-segment driver for a 3-digit BCD score.
//            The score is snapshotted once per frame so a frame never tears.
//            Leading zeros are blanked and invalid digits are shown as a dash.
//            Each slot starts with an all-anodes-off guard interval to stop
//            ghosting between digits.
// Revision : 1.0 - initial release
// ============================================================================
module score_display #(
  parameter int SLOT_CYCLES  = 100000,
  parameter int GUARD_CYCLES = 2000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] ones,
  input  logic [3:0] tens,
  input  logic [3:0] hundreds,
  input  logic       blank,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       frame_tick
);

  localparam int             CNT_W     = $clog2(SLOT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_END = CNT_W'(GUARD_CYCLES);
  localparam logic [6:0]     SEG_BLANK = 7'b1111111;
  localparam logic [6:0]     SEG_DASH  = 7'b0111111;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       snap_o_q, snap_o_d;
  logic [3:0]       snap_t_q, snap_t_d;
  logic [3:0]       snap_h_q, snap_h_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;
  logic             tick_q, tick_d;

  logic             slot_last;
  logic             frame_last;
  logic [3:0]       digit;
  logic             digit_blank;

  // Active-low segment pattern (bit 6 = g ... bit 0 = a) for one BCD value.
  function automatic logic [6:0] encode(input logic [3:0] d);
    logic [6:0] p;
    p = SEG_DASH;
    case (d)
      4'd0: p = 7'b1000000;
      4'd1: p = 7'b1111001;
      4'd2: p = 7'b0100100;
      4'd3: p = 7'b0110000;
      4'd4: p = 7'b0011001;
      4'd5: p = 7'b0010010;
      4'd6: p = 7'b0000010;
      4'd7: p = 7'b1111000;
      4'd8: p = 7'b0000000;
      4'd9: p = 7'b0010000;
      default: p = SEG_DASH;
    endcase
    return p;
  endfunction

  assign slot_last  = (cnt_q == CNT_LAST);
  assign frame_last = slot_last && (idx_q == 2'd3);

  // Pick the snapshot digit for the current slot and decide leading-zero blanking.
  // Only all-zero leading positions blank, so an invalid value is never hidden.
  always_comb begin
    digit       = 4'd0;
    digit_blank = 1'b1;
    case (idx_q)
      2'd0: begin
        digit       = snap_o_q;
        digit_blank = 1'b0;
      end
      2'd1: begin
        digit       = snap_t_q;
        digit_blank = (snap_h_q == 4'd0) && (snap_t_q == 4'd0);
      end
      2'd2: begin
        digit       = snap_h_q;
        digit_blank = (snap_h_q == 4'd0);
      end
      default: begin
        digit       = 4'd0;
        digit_blank = 1'b1;
      end
    endcase
  end

  // Next-state for scan counters, frame snapshot and the registered outputs.
  always_comb begin
    cnt_d    = cnt_q + 1'b1;
    idx_d    = idx_q;
    snap_o_d = snap_o_q;
    snap_t_d = snap_t_q;
    snap_h_d = snap_h_q;
    if (slot_last) begin
      cnt_d = '0;
      idx_d = idx_q + 1'b1;
    end
    // Capture at the frame boundary so the whole next frame shows one score.
    if (frame_last) begin
      snap_o_d = ones;
      snap_t_d = tens;
      snap_h_d = hundreds;
    end

    seg_d = digit_blank ? SEG_BLANK : encode(digit);
    if ((cnt_q < GUARD_END) || blank || digit_blank) begin
      an_d = 4'b1111;
    end else begin
      an_d = ~(4'b0001 << idx_q);
    end
    // Registered off the last cycle of slot 3 so the pulse lines up with
    // the first cycle of slot 0 and never fires straight out of reset.
    tick_d = frame_last;
  end

  // State and output registers; reset forces all anodes and segments off at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      idx_q    <= 2'd0;
      snap_o_q <= 4'd0;
      snap_t_q <= 4'd0;
      snap_h_q <= 4'd0;
      seg_q    <= SEG_BLANK;
      an_q     <= 4'b1111;
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      snap_o_q <= snap_o_d;
      snap_t_q <= snap_t_d;
      snap_h_q <= snap_h_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      tick_q   <= tick_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = tick_q;
  assign dp         = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_score_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_score_display
// Brief    : Scoreboard bench for score_display. Stimulus pushes the expected
//            per-frame display (hand-derived segment patterns and lit slots)
//            into a queue; a monitor pops one record per frame start and
//            checks every cycle of that frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_score_display;

  localparam int SLOT  = 8;
  localparam int GUARD = 2;
  localparam int FRAME = 4 * SLOT;
  localparam int NVEC  = 9;

  typedef struct packed {
    logic [6:0] s0;
    logic [6:0] s1;
    logic [6:0] s2;
    logic [2:0] lit;
    logic [7:0] blo;
    logic [7:0] bhi;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] ones = 4'd0;
  logic [3:0] tens = 4'd0;
  logic [3:0] hundreds = 4'd0;
  logic       blank = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       frame_tick;

  int   checks = 0;
  int   errors = 0;
  int   mk = 0;
  bit   in_rst = 1'b1;
  bit   active = 1'b0;
  rec_t cur;
  rec_t q[$];

  rec_t       recs[NVEC];
  logic [3:0] v_o[NVEC];
  logic [3:0] v_t[NVEC];
  logic [3:0] v_h[NVEC];
  int         apply_at[NVEC];
  int         blank_at[NVEC];

  score_display #(
    .SLOT_CYCLES (SLOT),
    .GUARD_CYCLES(GUARD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ones      (ones),
    .tens      (tens),
    .hundreds  (hundreds),
    .blank     (blank),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (frame cycle %0d, t=%0t): got %h, expected %h", name, mk, $time, act, exp);
    end
  endtask

  task automatic pop_rec();
    if (q.size() > 0) begin
      cur    = q.pop_front();
      active = 1'b1;
    end else begin
      active = 1'b0;
    end
  endtask

  // Monitor: frame cycle mk counts from a frame start (reset release or tick).
  // Cycle mk shows slot (mk-1)/8 at position (mk-1)%8 due to the output register.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_rst = 1'b1;
        active = 1'b0;
      end else begin
        if (in_rst) begin
          in_rst = 1'b0;
          mk     = 0;
          pop_rec();
        end
        mk++;
        chk("dp", {31'd0, dp}, 32'd1);
        chk("frame_tick", {31'd0, frame_tick}, {31'd0, (mk == FRAME)});
        if (active && mk <= FRAME) begin
          int         slot;
          int         pos;
          logic [6:0] e_seg;
          logic [3:0] e_an;
          slot  = (mk - 1) / SLOT;
          pos   = (mk - 1) % SLOT;
          e_seg = (slot == 0) ? cur.s0 : (slot == 1) ? cur.s1 :
                  (slot == 2) ? cur.s2 : 7'b1111111;
          e_an  = 4'b1111;
          if (slot < 3 && cur.lit[slot] && pos >= GUARD &&
              !(mk >= int'(cur.blo) && mk <= int'(cur.bhi)))
            e_an = ~(4'b0001 << slot);
          chk("seg", {25'd0, seg}, {25'd0, e_seg});
          chk("an", {28'd0, an}, {28'd0, e_an});
        end
        if (frame_tick) begin
          mk = 0;
          pop_rec();
        end
      end
    end
  end

  task automatic apply(input int i);
    ones     = v_o[i];
    tens     = v_t[i];
    hundreds = v_h[i];
    q.push_back(recs[i]);
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick && n < FRAME + 8);
    chk("tick_timeout", {31'd0, frame_tick}, 32'd1);
  endtask

  task automatic set_vec(input int i, input logic [3:0] h, input logic [3:0] t,
                         input logic [3:0] o, input logic [6:0] s2, input logic [6:0] s1,
                         input logic [6:0] s0, input logic [2:0] lit, input int at,
                         input int bat);
    v_h[i]      = h;
    v_t[i]      = t;
    v_o[i]      = o;
    recs[i].s0  = s0;
    recs[i].s1  = s1;
    recs[i].s2  = s2;
    recs[i].lit = lit;
    apply_at[i] = at;
    blank_at[i] = bat;
    recs[i].blo = (bat > 0) ? 8'(bat + 1) : 8'd99;
    recs[i].bhi = (bat > 0) ? 8'(bat + 10) : 8'd0;
  endtask

  initial begin
    //        idx H      T      O      slot2        slot1        slot0        lit     at  blank
    set_vec(0, 4'd0,  4'd0,  4'd0, 7'b1111111, 7'b1111111, 7'b1000000, 3'b001, 0,  0);
    set_vec(1, 4'd0,  4'd0,  4'd0, 7'b1111111, 7'b1111111, 7'b1000000, 3'b001, 0,  0);
    set_vec(2, 4'd1,  4'd0,  4'd7, 7'b1111001, 7'b1000000, 7'b1111000, 3'b111, 10, 0);
    set_vec(3, 4'd0,  4'd5,  4'd3, 7'b1111111, 7'b0010010, 7'b0110000, 3'b011, 31, 0);
    set_vec(4, 4'd0,  4'd0,  4'd4, 7'b1111111, 7'b1111111, 7'b0011001, 3'b001, 5,  0);
    set_vec(5, 4'd0,  4'd0,  4'd6, 7'b1111111, 7'b1111111, 7'b0000010, 3'b001, 12, 0);
    set_vec(6, 4'd12, 4'd8,  4'd9, 7'b0111111, 7'b0000000, 7'b0010000, 3'b111, 20, 13);
    set_vec(7, 4'd0,  4'd10, 4'd2, 7'b1111111, 7'b0111111, 7'b0100100, 3'b011, 1,  0);
    set_vec(8, 4'd12, 4'd1,  4'd5, 7'b0111111, 7'b1111001, 7'b0010010, 3'b111, 25, 0);

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_an", {28'd0, an}, 32'hF);
    chk("rst_seg", {25'd0, seg}, 32'h7F);
    chk("rst_dp", {31'd0, dp}, 32'd1);
    chk("rst_tick", {31'd0, frame_tick}, 32'd0);

    // First frame after release shows the reset snapshot; vector 1 follows.
    q.push_back(recs[0]);
    apply(1);
    #2 rst_n = 1'b1;

    for (int i = 1; i < NVEC - 1; i++) begin
      wait_tick();
      for (int k = 1; k < FRAME; k++) begin
        @(negedge clk);
        if (blank_at[i] > 0 && k == blank_at[i]) blank = 1'b1;
        if (blank_at[i] > 0 && k == blank_at[i] + 10) blank = 1'b0;
        if (k == apply_at[i + 1]) apply(i + 1);
      end
    end

    // Frame showing vector 8: reset in slot 2 while still in the guard.
    wait_tick();
    for (int k = 1; k <= 17; k++) @(negedge clk);
    chk("pre_rst_seg", {25'd0, seg}, {25'd0, 7'b0111111});
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_an", {28'd0, an}, 32'hF);
    chk("async_rst_seg", {25'd0, seg}, 32'h7F);
    chk("async_rst_tick", {31'd0, frame_tick}, 32'd0);
    q.delete();
    q.push_back(recs[0]);
    q.push_back(recs[8]);
    repeat (3) @(negedge clk);
    chk("hold_rst_seg", {25'd0, seg}, 32'h7F);
    #2 rst_n = 1'b1;

    wait_tick();
    wait_tick();
    repeat (2) @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
